uart_tx_ctrl: RTL and testbench

// - UART transmit sequencer driven by the baud_en tick from baud_generate.
// - Accepts one parallel word per frame over a valid/ready handshake and serializes it onto txd.
// - Frame format: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// - txd changes only on baud_en ticks, so every bit lasts exactly one baud period.

---
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit sequencer.
// Accepts one word over a valid/ready handshake and sends it on txd as a frame:
// start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
// Every bit boundary falls on a baud_en tick from baud_generate.
// Build option: define UART_TX_PARITY_EN to insert the parity bit
// (even parity when PARITY_ODD = 0, odd parity when PARITY_ODD = 1).
module uart_tx_ctrl #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_en,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int unsigned     CntW     = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] BitLast  = CntW'(DATA_BITS - 1);
  localparam int unsigned     StopW    = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;
  localparam logic [StopW-1:0] StopLast = StopW'(STOP_BITS - 1);

  // Reject configurations the frame format cannot express.
  if (DATA_BITS < 5 || DATA_BITS > 8 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1)
  begin : g_bad_cfg
    $error("uart_tx_ctrl: DATA_BITS, STOP_BITS or PARITY_ODD out of range");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA, S_PARITY, S_STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_START, S_DATA, S_STOP
  } state_e;
`endif

  state_e                 state_q;
  logic [CntW-1:0]        bit_cnt_q;
  logic [StopW-1:0]       stop_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;

  logic accept;
  logic shift_en;

  assign tx_ready = (state_q == S_IDLE);
  assign accept   = tx_valid && (state_q == S_IDLE);
  // The register advances on the tick that puts the next data bit on txd.
  assign shift_en = baud_en &&
                    ((state_q == S_START) ||
                     ((state_q == S_DATA) && (bit_cnt_q != BitLast)));

`ifdef UART_TX_PARITY_EN
  logic [DATA_BITS-1:0] data_q;
  logic                 parity_bit;

  // Parity comes from the word captured at accept; tx_data may change mid-frame.
  assign parity_bit = (PARITY_ODD != 0) ? ~^data_q : ^data_q;

  // Keep an unshifted copy of the accepted word for the parity calculation.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= tx_data;
    end
  end
`endif

  // Data shift register: load on accept, shift right once per transmitted data bit.
  // NOTE: pure datapath with no reset; the FSM never reads it outside a frame, so a reset adds nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      shift_q <= tx_data;
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Frame sequencer with registered txd / tx_busy / tx_done.
  // NOTE: non-blocking assignments only, so every branch sees the pre-edge state and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      txd        <= 1'b1;
      tx_busy    <= 1'b0;
      tx_done    <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      tx_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          txd <= 1'b1;
          if (tx_valid) begin
            state_q    <= S_SYNC;
            tx_busy    <= 1'b1;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
          end
        end
        S_SYNC: begin
          if (baud_en) begin
            txd     <= 1'b0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (baud_en) begin
            txd     <= shift_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (baud_en) begin
            if (bit_cnt_q == BitLast) begin
`ifdef UART_TX_PARITY_EN
              txd     <= parity_bit;
              state_q <= S_PARITY;
`else
              txd     <= 1'b1;
              state_q <= S_STOP;
`endif
            end else begin
              txd       <= shift_q[0];
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_en) begin
            txd     <= 1'b1;
            state_q <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (baud_en) begin
            if (stop_cnt_q == StopLast) begin
              state_q <= S_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          txd     <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: self-checking bench for uart_tx_ctrl.
// Expected line bits come from a frame model built straight from the frame format
// (start, data LSB first, optional parity, stop bits), compared once per baud tick.
module tb_uart_tx_ctrl;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam int unsigned PARITY_ODD = 0;
  localparam int          P          = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          PAR_BITS   = 1;
`else
  localparam int          PAR_BITS   = 0;
`endif
  localparam int          NBITS      = 1 + DATA_BITS + PAR_BITS + STOP_BITS;

  logic                 clk;
  logic                 rst_n;
  logic                 baud_en;
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 txd;
  logic                 tx_busy;
  logic                 tx_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int phase   = 0;
  logic exp_q[$];

  uart_tx_ctrl #(
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (STOP_BITS),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_en  (baud_en),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .txd      (txd),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // One-clk baud tick every P clks, updated shortly after each rising edge.
  initial begin
    baud_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      phase   = (phase + 1) % P;
      baud_en = (phase == 0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame model: the line level for each bit period, in order.
  task automatic build_frame(input logic [DATA_BITS-1:0] w);
    logic par;
    exp_q = {};
    exp_q.push_back(1'b0);
    for (int i = 0; i < DATA_BITS; i++) exp_q.push_back(w[i]);
    if (PAR_BITS == 1) begin
      par = 1'b0;
      for (int i = 0; i < DATA_BITS; i++) par = par ^ w[i];
      if (PARITY_ODD != 0) par = ~par;
      exp_q.push_back(par);
    end
    for (int i = 0; i < STOP_BITS; i++) exp_q.push_back(1'b1);
  endtask

  // Present a word and wait for the handshake; returns the accept cycle and
  // whether a baud tick coincided with the accept edge.
  task automatic offer(input logic [DATA_BITS-1:0] w, input bit align,
                       output int acc_cyc, output bit acc_tick);
    logic rdy, be;
    bit   ok;
    for (int i = 0; i < 4 * P; i++) begin
      @(negedge clk);
      if (!align || baud_en) break;
    end
    tx_data  = w;
    tx_valid = 1'b1;
    ok       = 1'b0;
    acc_cyc  = -1;
    acc_tick = 1'b0;
    for (int i = 0; i < 400; i++) begin
      rdy = tx_ready;
      be  = baud_en;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok       = 1'b1;
        acc_cyc  = cyc;
        acc_tick = be;
        break;
      end
      @(negedge clk);
    end
    check("accept_timeout", ok, 1'b1);
  endtask

  // Follow one frame from just after its accept edge to tx_done.
  task automatic watch_frame(input string tag, input logic [DATA_BITS-1:0] w,
                             input int acc_cyc, input bit acc_tick,
                             input bit hold, input logic [DATA_BITS-1:0] next_w,
                             output int done_cyc);
    int   tick, first_cyc, glitch, spurious, busy_bad;
    logic last_txd;
    build_frame(w);
    check({tag, "_sync_txd"},   txd, 1'b1);
    check({tag, "_sync_busy"},  tx_busy, 1'b1);
    check({tag, "_sync_ready"}, tx_ready, 1'b0);
    check({tag, "_sync_done"},  tx_done, 1'b0);
    if (hold) tx_data = next_w;
    else tx_valid = 1'b0;
    tick = 0; first_cyc = -1; done_cyc = -1;
    glitch = 0; spurious = 0; busy_bad = 0;
    last_txd = txd;
    for (int c = 0; c < (NBITS + 3) * P && tick <= NBITS; c++) begin
      @(posedge clk);
      #1;
      if (!hold) tx_data = DATA_BITS'($urandom);
      if (baud_en) begin
        tick++;
        if (tick == 1) first_cyc = cyc;
        if (tick <= NBITS) begin
          check($sformatf("%s_bit%0d", tag, tick - 1), txd, exp_q[tick - 1]);
          if (tx_done) spurious++;
          if (!tx_busy) busy_bad++;
        end else begin
          done_cyc = cyc;
          check({tag, "_done"},  tx_done, 1'b1);
          check({tag, "_ready"}, tx_ready, 1'b1);
          check({tag, "_busy"},  tx_busy, 1'b0);
          check({tag, "_txd_idle"}, txd, 1'b1);
        end
      end else begin
        if (txd !== last_txd) glitch++;
        if (tx_done) spurious++;
        if (!tx_busy) busy_bad++;
      end
      last_txd = txd;
    end
    check({tag, "_frame_timeout"}, tick, NBITS + 1);
    check({tag, "_txd_between_ticks"}, glitch, 0);
    check({tag, "_spurious_done"}, spurious, 0);
    check({tag, "_busy_low"}, busy_bad, 0);
    if (acc_tick) check({tag, "_sync_wait"}, first_cyc - acc_cyc, P);
    else check({tag, "_sync_wait_range"},
               (first_cyc - acc_cyc >= 1) && (first_cyc - acc_cyc <= P), 1'b1);
    check({tag, "_frame_clks"}, done_cyc - first_cyc, NBITS * P);
    if (!hold) begin
      @(posedge clk);
      #1;
      check({tag, "_done_pulse"}, tx_done, 1'b0);
    end
  endtask

  initial begin
    int   acc_cyc, done_cyc, done2_cyc, tick, done_seen;
    bit   acc_tick;
    logic [DATA_BITS-1:0] w;

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = '0;

    // Reset: two edges with rst_n low.
    repeat (2) @(posedge clk);
    #1;
    check("rst_txd",   txd, 1'b1);
    check("rst_ready", tx_ready, 1'b1);
    check("rst_busy",  tx_busy, 1'b0);
    check("rst_done",  tx_done, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Directed 0xA5 frame.
    offer(8'hA5, 1'b0, acc_cyc, acc_tick);
    watch_frame("a5", 8'hA5, acc_cyc, acc_tick, 1'b0, '0, done_cyc);

    // Accept on the same edge as a baud tick: that tick must not start the frame.
    w = DATA_BITS'($urandom);
    offer(w, 1'b1, acc_cyc, acc_tick);
    check("coinc_aligned", acc_tick, 1'b1);
    watch_frame("coinc", w, acc_cyc, acc_tick, 1'b0, '0, done_cyc);

    // Back-to-back with tx_valid held: 0x00 then 0xFF.
    offer(8'h00, 1'b0, acc_cyc, acc_tick);
    watch_frame("b2b0", 8'h00, acc_cyc, acc_tick, 1'b1, 8'hFF, done_cyc);
    offer(8'hFF, 1'b0, acc_cyc, acc_tick);
    check("b2b_accept_gap", acc_cyc - done_cyc, 1);
    watch_frame("b2b1", 8'hFF, acc_cyc, acc_tick, 1'b0, '0, done2_cyc);

    // Reset while data bit 3 is on the line.
    w = DATA_BITS'($urandom);
    offer(w, 1'b0, acc_cyc, acc_tick);
    tx_valid = 1'b0;
    tick = 0;
    for (int c = 0; c < 10 * P && tick < 5; c++) begin
      @(posedge clk);
      #1;
      if (baud_en) tick++;
    end
    check("mid_reach_bit3", tick, 5);
    check("mid_bit3", txd, w[3]);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_txd",   txd, 1'b1);
    check("mid_rst_ready", tx_ready, 1'b1);
    check("mid_rst_busy",  tx_busy, 1'b0);
    check("mid_rst_done",  tx_done, 1'b0);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (NBITS * P) begin
      @(posedge clk);
      #1;
      if (tx_done) done_seen++;
    end
    check("mid_no_done", done_seen, 0);
    check("mid_idle_txd", txd, 1'b1);
    offer(8'h3C, 1'b0, acc_cyc, acc_tick);
    watch_frame("after_rst_3c", 8'h3C, acc_cyc, acc_tick, 1'b0, '0, done_cyc);

    // Randomized frames with random idle gaps and tick alignment.
    for (int k = 0; k < 20; k++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      w = DATA_BITS'($urandom);
      offer(w, 1'($urandom_range(0, 1)), acc_cyc, acc_tick);
      watch_frame($sformatf("rnd%0d", k), w, acc_cyc, acc_tick, 1'b0, '0, done_cyc);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
